dm_bist: RTL and testbench

Chainable built-in self-test stage for the word-addressed data memory. It sits in the self-test chain as a responder to the `start`/`finish` handshake: when `start` is seen, it runs a four-pass march over the memory through a dedicated port. It then raises a sticky `finish`, which can drive the next stage's `start` directly, and reports a pass/fail verdict and an error count.

---
 rtl/dm_bist.sv | 134 +++++++++++++
 tb/tb_dm_bist.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_bist.sv
// dm_bist: chainable four-pass march self-test for the word-addressed data
// memory. It launches on start, writes and reads back a per-address pattern
// and then its complement, and reports a sticky finish with a verdict and
// an error count.
module dm_bist #(
  parameter int          ADDR_W = 10,
  parameter int          DATA_W = 32,
  parameter int          DEPTH  = 1024,
  parameter logic [31:0] SEED   = 32'hA5A5_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              finish,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    W0,
    R0,
    W1,
    R1,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] SEED_T = DATA_W'(SEED);

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [DATA_W-1:0]   pat;
  logic [DATA_W-1:0]   expected;
  logic                mismatch;
  logic [15:0]         err_next;

  assign pat = SEED_T ^ DATA_W'(idx);

  // Memory port and read-compare decode from the registered state and index
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    expected  = pat;
    unique case (state)
      W0: begin
        mem_we    = 1'b1;
        mem_addr  = idx;
        mem_wdata = pat;
      end
      R0: begin
        mem_addr  = idx;
      end
      W1: begin
        mem_we    = 1'b1;
        mem_addr  = idx;
        mem_wdata = ~pat;
      end
      R1: begin
        mem_addr  = idx;
        expected  = ~pat;
      end
      default: ;
    endcase
  end

  // Mismatch detection and saturating next error count
  always_comb begin
    mismatch = ((state == R0) || (state == R1)) && (mem_rdata != expected);
    err_next = err_count;
    if (mismatch && (err_count != '1)) begin
      err_next = err_count + 16'd1;
    end
  end

  // March sequencer with registered verdict flags and error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= '0;
      finish          <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_addr <= '0;
    end else begin
      err_count <= err_next;
      // err_count is still zero exactly until the first mismatch is recorded
      if (mismatch && (err_count == '0)) begin
        first_fail_addr <= idx;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= W0;
            idx   <= '0;
          end
        end
        W0, R0, W1: begin
          if (idx == LAST) begin
            idx <= '0;
            if (state == W0)      state <= R0;
            else if (state == R0) state <= W1;
            else                  state <= R1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        R1: begin
          if (idx == LAST) begin
            idx    <= '0;
            state  <= DONE;
            finish <= 1'b1;
            pass   <= (err_next == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_bist.sv
// Bench for dm_bist: an 8-word stage with an injectable faulty memory model,
// chained into a 1-word stage that starts from the first stage's finish.
module tb_dm_bist;

  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;

  logic        finish, pass, mem_we;
  logic [15:0] err_count;
  logic [9:0]  first_fail_addr, mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        finish2, pass2, mem_we2;
  logic [15:0] err_count2;
  logic [9:0]  first_fail_addr2, mem_addr2;
  logic [31:0] mem_wdata2, mem_rdata2;

  logic [31:0] mem [8];
  logic [31:0] s0  [8];
  logic [31:0] s1  [8];
  logic [31:0] mem2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_bist #(.ADDR_W(10), .DATA_W(32), .DEPTH(8), .SEED(SEED)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .pass(pass),
    .err_count(err_count), .first_fail_addr(first_fail_addr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dm_bist #(.ADDR_W(10), .DATA_W(32), .DEPTH(1), .SEED(SEED)) u_chain (
    .clk(clk), .rst_n(rst_n), .start(finish), .finish(finish2), .pass(pass2),
    .err_count(err_count2), .first_fail_addr(first_fail_addr2),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2)
  );

  // Memory models: faulty 8-word array for stage 1, ideal word for stage 2
  assign mem_rdata  = (mem[mem_addr[2:0]] | s1[mem_addr[2:0]]) & ~s0[mem_addr[2:0]];
  assign mem_rdata2 = mem2;

  always @(posedge clk) begin
    if (mem_we)  mem[mem_addr[2:0]] <= mem_wdata;
    if (mem_we2) mem2 <= mem_wdata2;
  end

  typedef struct {
    string       name;
    int          addr;
    logic [31:0] m0;
    logic [31:0] m1;
    logic [15:0] e_err;
    logic [9:0]  e_ffa;
    logic        e_pass;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [31:0] pat(input int i);
    return SEED ^ 32'(i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 8; i++) begin
      s0[i] = '0;
      s1[i] = '0;
    end
  endtask

  // Reference: every write pass completes before its read pass, so each read
  // returns the fault-filtered pattern of that pass.
  task automatic model(output logic [15:0] e_err, output logic [9:0] e_ffa,
                       output logic e_pass);
    int cnt = 0;
    logic [31:0] w, r;
    e_ffa = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) begin
        w = (p == 0) ? pat(i) : ~pat(i);
        r = (w | s1[i]) & ~s0[i];
        if (r != w) begin
          if (cnt == 0) e_ffa = 10'(i);
          cnt++;
        end
      end
    end
    e_err  = 16'(cnt);
    e_pass = (cnt == 0);
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_finish"}, 32'(finish), 0);
    chk({nm, "_pass"},   32'(pass), 0);
    chk({nm, "_err"},    32'(err_count), 0);
    chk({nm, "_ffa"},    32'(first_fail_addr), 0);
    chk({nm, "_we"},     32'(mem_we), 0);
    chk({nm, "_addr"},   32'(mem_addr), 0);
    chk({nm, "_wdata"},  32'(mem_wdata), 0);
    chk({nm, "_fin2"},   32'(finish2), 0);
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Expected port activity k cycles after the launching edge
  task automatic chk_cycle(input int k);
    int ps = k / 8;
    int i  = k % 8;
    chk("run_finish_low", 32'(finish), 0);
    chk("run_we", 32'(mem_we), (ps == 0 || ps == 2) ? 1 : 0);
    chk("run_addr", 32'(mem_addr), 32'(i));
    if (ps == 0) chk("w0_data", mem_wdata, pat(i));
    if (ps == 2) chk("w1_data", mem_wdata, ~pat(i));
  endtask

  task automatic run_march(input int abort_k, input bit hold_start,
                           input logic [15:0] e_err, input logic [9:0] e_ffa,
                           input logic e_pass, input string nm);
    bit aborted = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      chk_cycle(k);
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        chk_cleared({nm, "_abort"});
        aborted = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!aborted) begin
      chk({nm, "_finish"}, 32'(finish), 1);
      chk({nm, "_pass"},   32'(pass), 32'(e_pass));
      chk({nm, "_err"},    32'(err_count), 32'(e_err));
      chk({nm, "_ffa"},    32'(first_fail_addr), 32'(e_ffa));
      chk({nm, "_we_done"}, 32'(mem_we), 0);
      // Chained 1-word stage: one cycle per pass after it sees finish
      chk("chain_idle", 32'(mem_we2), 0);
      for (int j = 0; j < 4; j++) begin
        @(posedge clk);
        #1;
        chk("chain_we", 32'(mem_we2), (j % 2 == 0) ? 1 : 0);
        chk("chain_addr", 32'(mem_addr2), 0);
        if (j == 0) chk("chain_w0", mem_wdata2, SEED);
        if (j == 2) chk("chain_w1", mem_wdata2, ~SEED);
        chk("chain_fin_low", 32'(finish2), 0);
      end
      @(posedge clk);
      #1;
      chk("chain_finish", 32'(finish2), 1);
      chk("chain_pass", 32'(pass2), 1);
      chk("chain_err", 32'(err_count2), 0);
      // Done is sticky and deaf to start
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk({nm, "_sticky"}, 32'(finish), 1);
      chk({nm, "_sticky_we"}, 32'(mem_we), 0);
      chk({nm, "_sticky_err"}, 32'(err_count), 32'(e_err));
      start = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] m_err;
    logic [9:0]  m_ffa;
    logic        m_pass;

    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem2 = '0;
    clear_faults();

    vecs[0] = '{"ideal",      0, 32'h0,        32'h0,        16'd0, 10'd0, 1'b1};
    vecs[1] = '{"b3_sa1_a5",  5, 32'h0,        32'h8,        16'd1, 10'd5, 1'b0};
    vecs[2] = '{"a2_zero",    2, 32'hFFFFFFFF, 32'h0,        16'd2, 10'd2, 1'b0};
    vecs[3] = '{"b0_sa0_a7",  7, 32'h1,        32'h0,        16'd1, 10'd7, 1'b0};
    vecs[4] = '{"b31_sa1_a0", 0, 32'h0,        32'h80000000, 16'd1, 10'd0, 1'b0};

    for (int v = 0; v < 5; v++) begin
      clear_faults();
      s0[vecs[v].addr] = vecs[v].m0;
      s1[vecs[v].addr] = vecs[v].m1;
      do_reset();
      run_march(-1, 0, vecs[v].e_err, vecs[v].e_ffa, vecs[v].e_pass, vecs[v].name);
    end

    // Idle with start low, then a one-cycle pulse
    clear_faults();
    do_reset();
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      chk("idle_we", 32'(mem_we), 0);
      chk("idle_finish", 32'(finish), 0);
    end
    run_march(-1, 0, 16'd0, 10'd0, 1'b1, "after_idle");

    // Abort during R0, stay idle, relaunch with start held high
    do_reset();
    run_march(12, 0, 16'd0, 10'd0, 1'b1, "abort_r0");
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("post_abort_idle", 32'(mem_we), 0);
    end
    run_march(-1, 1, 16'd0, 10'd0, 1'b1, "rerun");

    // Abort during W1 after an error has been counted
    s1[5] = 32'h8;
    do_reset();
    run_march(20, 0, 16'd1, 10'd5, 1'b0, "abort_w1");
    #2;
    rst_n = 1'b1;
    run_march(-1, 1, 16'd1, 10'd5, 1'b0, "rerun_fault");

    // Randomized fault maps against the reference model
    for (int t = 0; t < 8; t++) begin
      clear_faults();
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 7))
          0: s0[i] = 32'h1 << $urandom_range(0, 31);
          1: s1[i] = 32'h1 << $urandom_range(0, 31);
          2: s0[i] = $urandom;
          3: s1[i] = $urandom;
          default: ;
        endcase
      end
      model(m_err, m_ffa, m_pass);
      do_reset();
      run_march(-1, 0, m_err, m_ffa, m_pass, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
